regfile_arbiter: RTL and testbench
==================================

Name: regfile_arbiter

Overview:
- Sequences and shares the single write port and the rs2 read port of the W x 2^N register file (x0 hard-wired zero) between the core and a debug/loader port.
- Performs a sequential zero-clear of registers 1..2^N-1 after reset and on request. The core is stalled while the clear runs.
- Sits between the core writeback/decode stage and the register file. Register-file outputs are driven combinationally from state.

Parameters:
W, 32, data width.
N, 5, register address width (2^N registers).
STARVE_LIM, 8, debug-write wait cycles before the core is forced to stall (only with REGFILE_ARB_STARVE_EN).

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
clear_req  in  1  pulse: start a clear sequence (sampled in IDLE only).
core_we  in  1  core writeback enable.
core_rd  in  N  core destination register.
core_data  in  W  core writeback data.
core_rs2  in  N  core rs2 read address.
core_stall  out  1  core must hold PC and drop this cycle's writeback.
dbg_req  in  1  debug access request; held until dbg_gnt.
dbg_wr  in  1  1 = write, 0 = read.
dbg_addr  in  N  debug register address.
dbg_wdata  in  W  debug write data.
dbg_gnt  out  1  access accepted this cycle.
dbg_rvalid  out  1  dbg_rdata valid (one-cycle pulse).
dbg_rdata  out  W  registered read data.
rf_we  out  1  to register file write enable.
rf_rd  out  N  to register file destination register.
rf_wdata  out  W  to register file write data.
rf_rs2  out  N  to register file rs2 address.
rf_data_rs2  in  W  register file rs2 read data.
busy  out  1  high while in CLEAR.

Behaviour:
- States: CLEAR and IDLE.
- Reset values: state=CLEAR, clr_ptr=1, wait_cnt=0, dbg_rvalid=0, dbg_rdata=0.
- CLEAR:
  - Outputs: rf_we=1, rf_rd=clr_ptr, rf_wdata=0, rf_rs2=core_rs2, core_stall=1, busy=1, dbg_gnt=0.
  - clr_ptr increments each cycle.
  - When clr_ptr==2^N-1: next state IDLE, clr_ptr reloads 1.
  - Duration is exactly 2^N-1 cycles. Register 0 is never written.
- IDLE default (pass-through): rf_we=core_we, rf_rd=core_rd, rf_wdata=core_data, rf_rs2=core_rs2, core_stall=0, busy=0.
- IDLE debug read (dbg_req & !dbg_wr):
  - Same cycle: dbg_gnt=1, core_stall=1, rf_rs2=dbg_addr, rf_we=0.
  - Next edge: dbg_rdata<=rf_data_rs2, dbg_rvalid<=1 for one cycle.
  - Read latency is 1 cycle from grant. A read of register 0 returns 0.
- IDLE debug write (dbg_req & dbg_wr):
  - Free slot (core_we==0 or core_rd==0): dbg_gnt=1; rf_we=1, rf_rd=dbg_addr, rf_wdata=dbg_wdata; wait_cnt<=0.
  - Otherwise: the core write proceeds, dbg_gnt=0, wait_cnt increments, saturating at STARVE_LIM.
  - A debug write to register 0 is granted and has no effect.
- wait_cnt clears whenever dbg_req=0 or dbg_gnt=1.
- clear_req in IDLE:
  - The current cycle is serviced normally.
  - CLEAR is entered next cycle and outstanding debug requests wait.
  - clear_req has priority over starvation logic in the transition decision.
- Back-to-back debug requests are allowed every cycle. Reads stall the core each cycle they are granted.
- rst_n asserted mid-CLEAR: clr_ptr returns to 1 and the full sequence restarts after release.
- rst_n asserted with dbg_rvalid pending: the pulse is lost and dbg_rdata=0.

Optional Feature:
- Macro: REGFILE_ARB_STARVE_EN.
- Defined: in IDLE with a debug write pending and wait_cnt==STARVE_LIM, core_stall=1 and the debug write is granted regardless of core_we. The core write that cycle is dropped and replayed by the stalled core.
- Undefined: no counter logic is built, wait_cnt is absent, and debug writes are granted only in free slots (starvation possible).

Test Plan:
- Release rst_n -> busy=1 and rf_we=1 for 31 cycles with rf_rd=1..31 and rf_wdata=0, core_stall=1; then busy=0 and pass-through (core_we=1, rd=5, data=0xA5A5A5A5 appears on rf_*).
- IDLE, core_we=0, debug write addr=7 data=0x12345678 -> same-cycle dbg_gnt=1, rf_we=1, rf_rd=7; a subsequent debug read of 7 -> core_stall=1 one cycle, next cycle dbg_rvalid=1 and dbg_rdata=0x12345678.
- Debug read of addr 0 with rf_data_rs2 modelled as 0 -> dbg_rdata=0; debug write to 0 -> dbg_gnt=1 and no register change.
- core_we=1 to rd=3 every cycle plus a pending debug write: with REGFILE_ARB_STARVE_EN, grant occurs after 8 waiting cycles with core_stall=1 that cycle; without the macro, no grant until core_we drops.
- clear_req pulsed in IDLE together with a debug write request -> current cycle serviced; then 31 clear cycles; the debug request is granted only after busy falls.
- rst_n asserted at clear cycle 10 and released -> clear restarts at rf_rd=1 and runs the full 31 cycles.

Source files
------------

// File: rtl/regfile_arbiter.sv
// Shares the register-file write port and rs2 read port between the core and a debug port,
// and zero-clears x1..x(2^N-1) after reset or on clear_req. Optional macro: REGFILE_ARB_STARVE_EN.
module regfile_arbiter #(
    parameter int W          = 32,
    parameter int N          = 5,
    parameter int STARVE_LIM = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear_req,
    input  logic         core_we,
    input  logic [N-1:0] core_rd,
    input  logic [W-1:0] core_data,
    input  logic [N-1:0] core_rs2,
    output logic         core_stall,
    input  logic         dbg_req,
    input  logic         dbg_wr,
    input  logic [N-1:0] dbg_addr,
    input  logic [W-1:0] dbg_wdata,
    output logic         dbg_gnt,
    output logic         dbg_rvalid,
    output logic [W-1:0] dbg_rdata,
    output logic         rf_we,
    output logic [N-1:0] rf_rd,
    output logic [W-1:0] rf_wdata,
    output logic [N-1:0] rf_rs2,
    input  logic [W-1:0] rf_data_rs2,
    output logic         busy
);
    typedef enum logic {S_CLEAR = 1'b0, S_IDLE = 1'b1} state_e;

    localparam logic [N-1:0] PTR_FIRST = N'(1);
    localparam logic [N-1:0] PTR_LAST  = '1;

    state_e       state_q, state_d;
    logic [N-1:0] clr_ptr_q, clr_ptr_d;
    logic         dbg_rvalid_q, dbg_rvalid_d;
    logic [W-1:0] dbg_rdata_q, dbg_rdata_d;
    logic         dbg_rd_req, dbg_wr_req, free_slot, starve;

    assign dbg_rd_req = dbg_req & ~dbg_wr;
    assign dbg_wr_req = dbg_req & dbg_wr;
    // a core writeback to x0 leaves the write port effectively unused
    assign free_slot  = ~core_we | (core_rd == '0);

`ifdef REGFILE_ARB_STARVE_EN
    localparam int            CW  = $clog2(STARVE_LIM + 1);
    localparam logic [CW-1:0] LIM = CW'(STARVE_LIM);

    logic [CW-1:0] wait_cnt_q, wait_cnt_d;

    assign starve = dbg_wr_req & (wait_cnt_q == LIM);

    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (!dbg_req || dbg_gnt)
            wait_cnt_d = '0;
        else if (state_q == S_IDLE && wait_cnt_q != LIM)
            wait_cnt_d = wait_cnt_q + CW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) wait_cnt_q <= '0;
        else        wait_cnt_q <= wait_cnt_d;
    end
`else
    assign starve = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_CLEAR;
            clr_ptr_q    <= PTR_FIRST;
            dbg_rvalid_q <= 1'b0;
            dbg_rdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            clr_ptr_q    <= clr_ptr_d;
            dbg_rvalid_q <= dbg_rvalid_d;
            dbg_rdata_q  <= dbg_rdata_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        clr_ptr_d    = clr_ptr_q;
        dbg_rvalid_d = 1'b0;
        dbg_rdata_d  = dbg_rdata_q;
        case (state_q)
            S_CLEAR: begin
                if (clr_ptr_q == PTR_LAST) begin
                    state_d   = S_IDLE;
                    clr_ptr_d = PTR_FIRST;
                end else begin
                    clr_ptr_d = clr_ptr_q + N'(1);
                end
            end
            default: begin
                if (clear_req) state_d = S_CLEAR;
                if (dbg_rd_req) begin
                    dbg_rvalid_d = 1'b1;
                    dbg_rdata_d  = (dbg_addr == '0) ? '0 : rf_data_rs2;
                end
            end
        endcase
    end

    always_comb begin
        rf_we      = core_we;
        rf_rd      = core_rd;
        rf_wdata   = core_data;
        rf_rs2     = core_rs2;
        core_stall = 1'b0;
        busy       = 1'b0;
        dbg_gnt    = 1'b0;
        if (state_q == S_CLEAR) begin
            rf_we      = 1'b1;
            rf_rd      = clr_ptr_q;
            rf_wdata   = '0;
            core_stall = 1'b1;
            busy       = 1'b1;
        end else if (dbg_rd_req) begin
            dbg_gnt    = 1'b1;
            core_stall = 1'b1;
            rf_rs2     = dbg_addr;
            rf_we      = 1'b0;
        end else if (dbg_wr_req && (free_slot || starve)) begin
            // a forced grant drops the core write; the stalled core replays it
            dbg_gnt    = 1'b1;
            core_stall = starve;
            rf_we      = 1'b1;
            rf_rd      = dbg_addr;
            rf_wdata   = dbg_wdata;
        end
    end

    assign dbg_rvalid = dbg_rvalid_q;
    assign dbg_rdata  = dbg_rdata_q;

endmodule

// File: tb/tb_regfile_arbiter.sv
// Bench for regfile_arbiter: directed scenarios plus a randomized run against a register-level model.
module tb_regfile_arbiter;
    localparam int W = 32;
    localparam int N = 5;
`ifdef REGFILE_ARB_STARVE_EN
    localparam bit STARVE_ON = 1'b1;
`else
    localparam bit STARVE_ON = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic         clear_req, core_we, dbg_req, dbg_wr;
    logic [N-1:0] core_rd, core_rs2, dbg_addr;
    logic [W-1:0] core_data, dbg_wdata;
    logic         core_stall, dbg_gnt, dbg_rvalid, rf_we, busy;
    logic [W-1:0] dbg_rdata, rf_wdata, rf_data_rs2;
    logic [N-1:0] rf_rd, rf_rs2;

    logic [W-1:0] rf_mem [32];
    logic         fill_garbage;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    regfile_arbiter dut (
        .clk(clk), .rst_n(rst_n), .clear_req(clear_req),
        .core_we(core_we), .core_rd(core_rd), .core_data(core_data), .core_rs2(core_rs2),
        .core_stall(core_stall),
        .dbg_req(dbg_req), .dbg_wr(dbg_wr), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
        .rf_we(rf_we), .rf_rd(rf_rd), .rf_wdata(rf_wdata), .rf_rs2(rf_rs2),
        .rf_data_rs2(rf_data_rs2), .busy(busy)
    );

    // register file with hard-wired x0, preloaded with non-zero junk
    always @(posedge clk) begin
        if (fill_garbage) begin
            for (int i = 0; i < 32; i++) rf_mem[i] <= 32'hDEAD_0000 | 32'(i);
        end else if (rf_we && rf_rd != '0) begin
            rf_mem[rf_rd] <= rf_wdata;
        end
    end
    assign rf_data_rs2 = (rf_rs2 == '0) ? '0 : rf_mem[rf_rs2];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_clear(input string tag, input int ncyc);
        for (int i = 1; i <= ncyc; i++) begin
            @(negedge clk);
            chk(tag, {busy, rf_we, core_stall, dbg_gnt, rf_rd, rf_wdata},
                {1'b1, 1'b1, 1'b1, 1'b0, 5'(i), 32'h0});
            tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [W-1:0] acc, snap;
        logic         got;
        logic [W-1:0] model_rf [32];
        int           wcnt, mism;
        logic         hold, free, eg, es, cw, dw, exp_rv;
        logic [N-1:0] ers2;
        logic [W-1:0] exp_rd;

        rst_n = 1'b0; fill_garbage = 1'b1; clear_req = 1'b0;
        core_we = 1'b0; core_rd = '0; core_data = '0; core_rs2 = '0;
        dbg_req = 1'b0; dbg_wr = 1'b0; dbg_addr = '0; dbg_wdata = '0;
        repeat (2) @(posedge clk);
        #1 fill_garbage = 1'b0;
        @(negedge clk);
        chk("reset_state", {busy, core_stall, rf_we, rf_rd, dbg_rvalid, dbg_rdata},
            {1'b1, 1'b1, 1'b1, 5'd1, 1'b0, 32'h0});
        tick();
        rst_n = 1'b1;

        run_clear("clear_seq", 31);
        acc = '0;
        for (int i = 1; i < 32; i++) acc |= rf_mem[i];
        chk("clear_zero", acc, 0);

        core_we = 1'b1; core_rd = 5'd5; core_data = 32'hA5A5_A5A5; core_rs2 = 5'd9;
        @(negedge clk);
        chk("passthru", {busy, core_stall, rf_we, rf_rd, rf_wdata, rf_rs2},
            {1'b0, 1'b0, 1'b1, 5'd5, 32'hA5A5_A5A5, 5'd9});
        tick();

        core_we = 1'b0; dbg_req = 1'b1; dbg_wr = 1'b1; dbg_addr = 5'd7; dbg_wdata = 32'h1234_5678;
        @(negedge clk);
        chk("dbg_wr7", {dbg_gnt, core_stall, rf_we, rf_rd, rf_wdata},
            {1'b1, 1'b0, 1'b1, 5'd7, 32'h1234_5678});
        tick();

        dbg_wr = 1'b0; core_we = 1'b1; core_rd = 5'd8; core_data = 32'hFFFF_FFFF;
        @(negedge clk);
        chk("dbg_rd7_ctl", {dbg_gnt, core_stall, rf_we, rf_rs2}, {1'b1, 1'b1, 1'b0, 5'd7});
        tick();
        dbg_req = 1'b0; core_we = 1'b0;
        chk("dbg_rd7_data", {dbg_rvalid, dbg_rdata}, {1'b1, 32'h1234_5678});
        chk("dropped_core_wr", rf_mem[8], 0);
        tick();
        chk("rvalid_pulse", dbg_rvalid, 0);

        dbg_req = 1'b1; dbg_wr = 1'b0; dbg_addr = 5'd0;
        tick();
        chk("dbg_rd0", {dbg_rvalid, dbg_rdata}, {1'b1, 32'h0});

        snap = '0;
        for (int i = 1; i < 32; i++) snap ^= rf_mem[i] ^ 32'(i * 7);
        dbg_wr = 1'b1; dbg_wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("dbg_wr0_gnt", dbg_gnt, 1);
        tick();
        dbg_req = 1'b0;
        acc = '0;
        for (int i = 1; i < 32; i++) acc ^= rf_mem[i] ^ 32'(i * 7);
        chk("dbg_wr0_noeffect", acc, snap);

        // core writes every cycle while a debug write waits
        dbg_req = 1'b1; dbg_wr = 1'b1; dbg_addr = 5'd9; dbg_wdata = 32'h9999_0000;
        core_we = 1'b1; core_rd = 5'd3; core_data = 32'h3333_0000;
        got = 1'b0;
        for (int k = 0; k < 12 && !got; k++) begin
            @(negedge clk);
`ifdef REGFILE_ARB_STARVE_EN
            chk("starve_gnt", {dbg_gnt, core_stall}, (k == 8) ? 2'b11 : 2'b00);
`else
            chk("nostarve_gnt", {dbg_gnt, core_stall}, 2'b00);
`endif
            got = dbg_gnt;
            tick();
        end
        if (!got) begin
            core_we = 1'b0;
            @(negedge clk);
            chk("late_gnt", dbg_gnt, 1);
            tick();
        end
        dbg_req = 1'b0; core_we = 1'b0;
        chk("starve_rf9", rf_mem[9], 32'h9999_0000);
        chk("starve_rf3", rf_mem[3], 32'h3333_0000);

        // clear request with a debug write that cannot be granted this cycle
        clear_req = 1'b1; core_we = 1'b1; core_rd = 5'd4; core_data = 32'h4444_0000;
        dbg_req = 1'b1; dbg_wr = 1'b1; dbg_addr = 5'd11; dbg_wdata = 32'hBBBB_0000;
        @(negedge clk);
        chk("clrreq_cycle", {busy, dbg_gnt, rf_we, rf_rd}, {1'b0, 1'b0, 1'b1, 5'd4});
        tick();
        clear_req = 1'b0; core_we = 1'b0;
        run_clear("clear_req_seq", 31);
        @(negedge clk);
        chk("post_clear_gnt", {busy, dbg_gnt, rf_rd}, {1'b0, 1'b1, 5'd11});
        tick();
        dbg_req = 1'b0;
        chk("post_clear_rf", {rf_mem[11], rf_mem[4], rf_mem[9]}, {32'hBBBB_0000, 64'h0});

        // reset while a read pulse is pending, then reset mid-clear
        dbg_req = 1'b1; dbg_wr = 1'b1; dbg_addr = 5'd12; dbg_wdata = 32'hCAFE_F00D;
        tick();
        dbg_wr = 1'b0;
        tick();
        dbg_req = 1'b0;
        chk("rd12_data", {dbg_rvalid, dbg_rdata}, {1'b1, 32'hCAFE_F00D});
        rst_n = 1'b0;
        #1;
        chk("rst_rvalid_lost", {dbg_rvalid, dbg_rdata, busy, rf_rd}, {1'b0, 32'h0, 1'b1, 5'd1});
        tick();
        rst_n = 1'b1;
        run_clear("clear_pre_abort", 10);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_clear", {busy, rf_rd}, {1'b1, 5'd1});
        tick();
        rst_n = 1'b1;
        run_clear("clear_restart", 31);
        @(negedge clk);
        chk("restart_done", busy, 0);
        tick();

        // randomized traffic against a register-level model (all registers zero now)
        for (int i = 0; i < 32; i++) model_rf[i] = '0;
        wcnt = 0; hold = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (!hold) begin
                dbg_req   = ($urandom_range(0, 2) == 0);
                dbg_wr    = 1'($urandom_range(0, 1));
                dbg_addr  = 5'($urandom_range(0, 31));
                dbg_wdata = $urandom;
            end
            core_we   = 1'($urandom_range(0, 1));
            core_rd   = 5'($urandom_range(0, 31));
            core_data = $urandom;
            core_rs2  = 5'($urandom_range(0, 31));

            free = !core_we || core_rd == '0;
            eg = 1'b0; es = 1'b0; dw = 1'b0; ers2 = core_rs2;
            cw = core_we && core_rd != '0;
            exp_rv = dbg_req && !dbg_wr;
            exp_rd = model_rf[dbg_addr];
            if (dbg_req && !dbg_wr) begin
                eg = 1'b1; es = 1'b1; ers2 = dbg_addr; cw = 1'b0;
            end else if (dbg_req && dbg_wr) begin
                if (STARVE_ON && wcnt == 8) begin
                    eg = 1'b1; es = 1'b1; cw = 1'b0; dw = 1'b1;
                end else if (free) begin
                    eg = 1'b1; dw = 1'b1;
                end
            end

            @(negedge clk);
            chk("rnd_ctl", {dbg_gnt, core_stall, busy, rf_rs2}, {eg, es, 1'b0, ers2});

            if (cw) model_rf[core_rd] = core_data;
            if (dw && dbg_addr != '0) model_rf[dbg_addr] = dbg_wdata;
            if (!dbg_req || eg) wcnt = 0;
            else if (wcnt < 8) wcnt++;
            hold = dbg_req && !eg;

            tick();
            chk("rnd_rvalid", dbg_rvalid, exp_rv);
            if (exp_rv) chk("rnd_rdata", dbg_rdata, exp_rd);
        end
        dbg_req = 1'b0; core_we = 1'b0;
        mism = 0;
        for (int i = 1; i < 32; i++) if (rf_mem[i] !== model_rf[i]) mism++;
        chk("rnd_rf_contents", mism, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
